fft_frame_sequencer: RTL
========================

Name: fft_frame_sequencer

Overview:
- Schedules audio capture into the FFT core for tone detection.
- Slices one recording into NUM_FRAMES evenly spaced FFT frames and streams each frame into the FFT input.
- Tracks the peak-magnitude bin of each FFT output frame.
- Hands the ordered peak bins to the tone-detection FSM over a valid/ready stream, then signals done.

Parameters:
- FFT_LEN, 1024, samples per FFT frame; power of 2, at least 8.
- NUM_FRAMES, 4, frames per recording; power of 2, at least 2.
- SAMPLE_W, 16, signed audio sample width.
- MAG_W, 32, unsigned FFT magnitude width.
- BIN_W (localparam), $clog2(FFT_LEN), bin index width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- start_in  input  1  pulse; begins a recording sequence; ignored unless IDLE.
- recording_length  input  32  samples in the recording; sampled on the start_in cycle.
- sample_in  input  SAMPLE_W  signed audio sample.
- sample_valid_in  input  1  sample_in valid this cycle.
- fft_s_data_out  output  SAMPLE_W  sample to FFT.
- fft_s_valid_out  output  1  FFT input valid.
- fft_s_last_out  output  1  final sample of a frame.
- fft_s_ready_in  input  1  FFT input ready.
- fft_m_mag_in  input  MAG_W  FFT output magnitude.
- fft_m_valid_in  input  1  FFT output valid.
- fft_m_last_in  input  1  FFT output last bin.
- peak_bin_out  output  BIN_W  peak bin of current frame.
- peak_valid_out  output  1  peak_bin_out valid.
- peak_last_out  output  1  final frame's peak.
- peak_ready_in  input  1  tone detector ready.
- busy_out  output  1  high in any state other than IDLE.
- done_out  output  1  one-cycle pulse after the final peak handshake.
- error_out  output  2  sticky: [0] sample overrun, [1] FFT framing error.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE; all counters and the peak buffer cleared.
  - Reset mid-sequence abandons it; no partial results are emitted.
- stride = recording_length >> log2(NUM_FRAMES), latched on start_in.
  - If stride < FFT_LEN, stride is forced to FFT_LEN (frames contiguous).
- Control FSM states:
  - IDLE: start_in -> FEED. Clears frame_idx, peak count and error_out.
  - FEED: each sample_valid_in sample is registered to fft_s_data_out with fft_s_valid_out, one cycle of latency. sample_cnt increments.
    - The FFT_LEN-th sample asserts fft_s_last_out.
    - If fft_s_ready_in is low while fft_s_valid_out is high, the new incoming sample is dropped, error_out[0] is set, and the held output stays stable.
    - After the last sample: go to SKIP if stride > FFT_LEN, else FEED for the next frame. Go to WAIT_RES when frame_idx reaches NUM_FRAMES-1.
  - SKIP: discards stride-FFT_LEN valid samples, then -> FEED.
  - WAIT_RES: waits until peak count == NUM_FRAMES, then -> EMIT.
  - EMIT: presents buffer[0..NUM_FRAMES-1] in order.
    - Advances on peak_valid_out && peak_ready_in.
    - peak_last_out is high with entry NUM_FRAMES-1.
    - Data is held stable while stalled.
    - After the last handshake: done_out pulses and state -> IDLE.
- Peak tracker runs independently of the control FSM, so it overlaps FEED of later frames:
  - bin_cnt increments on each fft_m_valid_in.
  - Only bins 1..FFT_LEN/2-1 are compared: DC and the mirror half are ignored.
  - Strict greater-than compare, so ties keep the lower bin.
  - On the fft_m_last_in beat, the frame's peak is written to buffer[peak count] the next cycle, then bin_cnt, the running max and the running bin are cleared.
  - If fft_m_last_in arrives with bin_cnt != FFT_LEN-1, error_out[1] is set and the peak is still written.
  - If fft_m_valid_in arrives when peak count == frames fed, or in IDLE, the beat is ignored and error_out[1] is set.
- Simultaneous events:
  - start_in while busy is ignored.
  - The peak write and a FEED last beat on the same cycle are both honoured.

Optional Feature:
- Macro: PEAK_THRESHOLD_EN.
- With the macro defined: adds input min_mag_in (MAG_W). If a frame's max magnitude < min_mag_in, that frame's peak is reported as bin 0 (silence marker).
- Without the macro: no min_mag_in port; the max bin is always reported.

Test Plan:
1. FFT_LEN=8, NUM_FRAMES=4, recording_length=64, ready always high, stride 16, so each frame is 8 samples fed then 8 skipped. Mock FFT peaks at bins 2,3,3,1 -> peak_bin_out 2,3,3,1, peak_last_out on the 4th, done_out pulses once, error_out=0.
2. recording_length=20, so stride 5 is forced to 8 -> 32 consecutive samples feed 4 frames; fft_s_last_out on samples 8,16,24,32.
3. Tie: mags equal at bins 2 and 3, plus a larger mag at bin 0 and bin 6 -> reported bin 2.
4. fft_s_ready_in low for 3 cycles during FEED with continuous samples -> error_out[0]=1, fft_s_data_out held stable; sequence still completes.
5. peak_ready_in low for 5 cycles in EMIT -> peak_bin_out and peak_valid_out held; all 4 peaks emitted in order. Then rst_in asserted mid-FEED of a new run -> all outputs 0 immediately, no done_out.
6. With PEAK_THRESHOLD_EN and min_mag_in=100, frame max=50 -> that frame reports 0; other frames unchanged.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// Slices one recording into NUM_FRAMES FFT frames, tracks each FFT output frame's peak bin and streams the peaks out.
// Optional PEAK_THRESHOLD_EN adds min_mag_in; frames whose max magnitude is below it report bin 0.
module fft_frame_sequencer #(
   parameter int FFT_LEN    = 1024,
   parameter int NUM_FRAMES = 4,
   parameter int SAMPLE_W   = 16,
   parameter int MAG_W      = 32,
   localparam int BIN_W     = $clog2(FFT_LEN)
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       start_in,
   input  logic [31:0]                recording_length,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic                       sample_valid_in,
   output logic signed [SAMPLE_W-1:0] fft_s_data_out,
   output logic                       fft_s_valid_out,
   output logic                       fft_s_last_out,
   input  logic                       fft_s_ready_in,
   input  logic [MAG_W-1:0]           fft_m_mag_in,
   input  logic                       fft_m_valid_in,
   input  logic                       fft_m_last_in,
`ifdef PEAK_THRESHOLD_EN
   input  logic [MAG_W-1:0]           min_mag_in,
`endif
   output logic [BIN_W-1:0]           peak_bin_out,
   output logic                       peak_valid_out,
   output logic                       peak_last_out,
   input  logic                       peak_ready_in,
   output logic                       busy_out,
   output logic                       done_out,
   output logic [1:0]                 error_out
);

   localparam int FRAME_W = $clog2(NUM_FRAMES);
   localparam logic [BIN_W-1:0]   LAST_BIN   = BIN_W'(FFT_LEN - 1);
   localparam logic [BIN_W-1:0]   HALF_LAST  = BIN_W'(FFT_LEN / 2 - 1);
   localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
   localparam logic [FRAME_W:0]   ALL_FRAMES = (FRAME_W + 1)'(NUM_FRAMES);
   localparam logic [31:0]        FFT_LEN32  = 32'(FFT_LEN);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] FEED     = 3'd1;
   localparam logic [2:0] SKIP     = 3'd2;
   localparam logic [2:0] WAIT_RES = 3'd3;
   localparam logic [2:0] EMIT     = 3'd4;

   logic [2:0]         state;
   logic [31:0]        stride;
   logic [31:0]        skip_cnt;
   logic [BIN_W-1:0]   sample_cnt;
   logic [FRAME_W-1:0] frame_idx;
   logic [FRAME_W:0]   frames_fed;
   logic [FRAME_W-1:0] emit_idx;
   logic               ovr_err;

   logic [BIN_W-1:0]   bin_cnt;
   logic [MAG_W-1:0]   run_max;
   logic [BIN_W-1:0]   run_bin;
   logic               wr_pend;
   logic [BIN_W-1:0]   wr_bin;
   logic [FRAME_W:0]   peak_cnt;
   logic [BIN_W-1:0]   peak_buf [NUM_FRAMES];
   logic               frm_err;

   logic        start_go;
   logic        out_stall;
   logic        feed_take;
   logic [31:0] stride_raw;
   logic [31:0] stride_next;
   logic [31:0] skip_len;

   assign start_go    = (state == IDLE) && start_in;
   assign out_stall   = fft_s_valid_out && !fft_s_ready_in;
   assign feed_take   = (state == FEED) && sample_valid_in && !out_stall;
   assign stride_raw  = recording_length >> FRAME_W;
   assign stride_next = (stride_raw < FFT_LEN32) ? FFT_LEN32 : stride_raw;
   assign skip_len    = stride - FFT_LEN32;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state           <= IDLE;
         stride          <= '0;
         skip_cnt        <= '0;
         sample_cnt      <= '0;
         frame_idx       <= '0;
         frames_fed      <= '0;
         emit_idx        <= '0;
         ovr_err         <= 1'b0;
         done_out        <= 1'b0;
         fft_s_data_out  <= '0;
         fft_s_valid_out <= 1'b0;
         fft_s_last_out  <= 1'b0;
      end else begin
         done_out <= 1'b0;

         // A held beat blocks new samples; anything arriving meanwhile is lost and flagged.
         if (feed_take) begin
            fft_s_data_out  <= sample_in;
            fft_s_valid_out <= 1'b1;
            fft_s_last_out  <= (sample_cnt == LAST_BIN);
         end else if (fft_s_valid_out && fft_s_ready_in) begin
            fft_s_valid_out <= 1'b0;
            fft_s_last_out  <= 1'b0;
         end
         if ((state == FEED) && sample_valid_in && out_stall) begin
            ovr_err <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start_in) begin
                  stride     <= stride_next;
                  skip_cnt   <= '0;
                  sample_cnt <= '0;
                  frame_idx  <= '0;
                  frames_fed <= '0;
                  emit_idx   <= '0;
                  ovr_err    <= 1'b0;
                  state      <= FEED;
               end
            end
            FEED: begin
               if (feed_take) begin
                  if (sample_cnt == LAST_BIN) begin
                     sample_cnt <= '0;
                     frames_fed <= frames_fed + 1'b1;
                     if (frame_idx == LAST_FRAME) begin
                        state <= WAIT_RES;
                     end else begin
                        frame_idx <= frame_idx + 1'b1;
                        if (stride > FFT_LEN32) begin
                           state <= SKIP;
                        end
                     end
                  end else begin
                     sample_cnt <= sample_cnt + 1'b1;
                  end
               end
            end
            SKIP: begin
               if (sample_valid_in) begin
                  if (skip_cnt == skip_len - 32'd1) begin
                     skip_cnt <= '0;
                     state    <= FEED;
                  end else begin
                     skip_cnt <= skip_cnt + 32'd1;
                  end
               end
            end
            WAIT_RES: begin
               if (peak_cnt == ALL_FRAMES) begin
                  emit_idx <= '0;
                  state    <= EMIT;
               end
            end
            EMIT: begin
               if (peak_ready_in) begin
                  if (emit_idx == LAST_FRAME) begin
                     emit_idx <= '0;
                     done_out <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     emit_idx <= emit_idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Peak tracking runs alongside FEED; a beat counts only while some fed frame still owes a result.
   logic             beat_ok;
   logic             in_band;
   logic             take_mag;
   logic [MAG_W-1:0] cand_max;
   logic [BIN_W-1:0] cand_bin;
   logic [BIN_W-1:0] final_bin;

   assign beat_ok  = fft_m_valid_in && (state != IDLE) &&
                     ((peak_cnt + (FRAME_W + 1)'(wr_pend)) != frames_fed);
   assign in_band  = (bin_cnt != '0) && (bin_cnt <= HALF_LAST);
   assign take_mag = in_band && (fft_m_mag_in > run_max);
   assign cand_max = take_mag ? fft_m_mag_in : run_max;
   assign cand_bin = take_mag ? bin_cnt : run_bin;
`ifdef PEAK_THRESHOLD_EN
   assign final_bin = (cand_max < min_mag_in) ? '0 : cand_bin;
`else
   assign final_bin = cand_bin;
`endif

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         bin_cnt  <= '0;
         run_max  <= '0;
         run_bin  <= '0;
         wr_pend  <= 1'b0;
         wr_bin   <= '0;
         peak_cnt <= '0;
         frm_err  <= 1'b0;
         for (int i = 0; i < NUM_FRAMES; i++) begin
            peak_buf[i] <= '0;
         end
      end else begin
         wr_pend <= 1'b0;
         if (start_go) begin
            bin_cnt  <= '0;
            run_max  <= '0;
            run_bin  <= '0;
            peak_cnt <= '0;
            frm_err  <= 1'b0;
         end else begin
            if (wr_pend) begin
               peak_buf[peak_cnt[FRAME_W-1:0]] <= wr_bin;
               peak_cnt <= peak_cnt + 1'b1;
            end
            if (fft_m_valid_in && !beat_ok) begin
               frm_err <= 1'b1;
            end else if (beat_ok) begin
               if (fft_m_last_in) begin
                  wr_pend <= 1'b1;
                  wr_bin  <= final_bin;
                  if (bin_cnt != LAST_BIN) begin
                     frm_err <= 1'b1;
                  end
                  bin_cnt <= '0;
                  run_max <= '0;
                  run_bin <= '0;
               end else begin
                  bin_cnt <= bin_cnt + 1'b1;
                  run_max <= cand_max;
                  run_bin <= cand_bin;
               end
            end
         end
      end
   end

   assign busy_out       = (state != IDLE);
   assign peak_valid_out = (state == EMIT);
   assign peak_bin_out   = (state == EMIT) ? peak_buf[emit_idx] : '0;
   assign peak_last_out  = (state == EMIT) && (emit_idx == LAST_FRAME);
   assign error_out      = {frm_err, ovr_err};

endmodule
